// File: rtl/dense_head_pkg.sv
// Shared types, constants and fixed-point helpers for the dense output head.
//  - dense_state_t : controller states of the dense head
//  - DEFAULT_*     : default vector length / fixed-point format
//  - sat16         : clamp a 32-bit signed value into the signed 16-bit range
//  - hard_sigmoid  : piecewise-linear sigmoid, result in 0 .. 1.0
package dense_head_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BIAS = 2'd2,
        ACT  = 2'd3
    } dense_state_t;

    localparam int DEFAULT_LEN_BITS  = 4;
    localparam int DEFAULT_FRAC_BITS = 8;

    // Clamp a 32-bit signed value into [-32768, 32767].
    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        logic signed [15:0] r;
        if (v > 32'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // clamp((x >>> 2) + 0.5, 0, 1.0) in a format with 'frac' fractional bits.
    function automatic logic [15:0] hard_sigmoid(input logic signed [15:0] x,
                                                 input int                 frac);
        logic signed [31:0] xe;
        logic signed [31:0] half;
        logic signed [31:0] one;
        logic signed [31:0] t;
        logic [15:0]        r;
        xe   = {{16{x[15]}}, x};
        one  = 32'sd1 <<< frac;
        half = 32'sd1 <<< (frac - 1);
        t    = (xe >>> 2) + half;
        if (t < 32'sd0) begin
            r = 16'd0;
        end else if (t > one) begin
            r = one[15:0];
        end else begin
            r = t[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dense_head_if.sv
// Bus between the RNN top level and the dense head.
//  start   : request one evaluation (only honoured while idle)
//  sel     : element index driven to the hidden and dense tensors
//  h_data  : hidden element at sel (combinational read)
//  w_data  : dense weight at sel (combinational read)
//  bias    : dense bias, held stable while busy
//  busy    : evaluation in progress
//  ready   : one-cycle pulse when logit/prob are refreshed
//  logit   : saturated pre-activation, signed 16-bit fixed point
//  prob    : hard-sigmoid probability, 0 .. 1.0
// master = requester / tensor owner, slave = dense head.
interface dense_head_if #(
    parameter int LEN_BITS = 4
);
    logic                start;
    logic [LEN_BITS-1:0] sel;
    logic signed [15:0]  h_data;
    logic signed [15:0]  w_data;
    logic signed [15:0]  bias;
    logic                busy;
    logic                ready;
    logic signed [15:0]  logit;
    logic [15:0]         prob;

    modport master (
        output start, h_data, w_data, bias,
        input  sel, busy, ready, logit, prob
    );

    modport slave (
        input  start, h_data, w_data, bias,
        output sel, busy, ready, logit, prob
    );
endinterface

// File: rtl/dense_head_fxp_mac.sv
// Fixed-point multiply-accumulate for the dense head.
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : zero the accumulator (wins over en)
//  en         : add floor((a*b) / 2**FRAC_BITS) into the accumulator
//  a, b       : signed 16-bit operands
//  acc        : registered 32-bit signed accumulator
module fxp_mac #(
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] acc
);
    logic signed [31:0] prod_s;
    logic signed [31:0] term_s;
    logic signed [31:0] acc_r;

    // Full-precision product, then arithmetic shift so the term rounds toward -inf.
    always_comb begin
        prod_s = 32'(a) * 32'(b);
        term_s = prod_s >>> FRAC_BITS;
    end

    // Accumulator register with clear priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'sd0;
        end else if (clr) begin
            acc_r <= 32'sd0;
        end else if (en) begin
            acc_r <= acc_r + term_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;
endmodule

// File: rtl/dense_head.sv
// Dense output head of the RNN accelerator.
// On start it walks the hidden/dense vectors via sel, accumulates the fixed-point
// products, adds the bias, saturates to a 16-bit logit and applies a hard sigmoid.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : dense_head_if slave port (start/sel/h_data/w_data/bias in,
//               busy/ready/logit/prob out)
// Timing from the start edge E0: N MAC edges, one BIAS edge, one ACT edge;
// ready is high in the cycle after the ACT edge.
module dense_head
    import dense_head_pkg::*;
#(
    parameter int LEN_BITS  = DEFAULT_LEN_BITS,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    dense_head_if.slave bus
);
    localparam logic [LEN_BITS-1:0] IDX_ZERO = {LEN_BITS{1'b0}};
    localparam logic [LEN_BITS-1:0] IDX_ONE  = LEN_BITS'(1);
    localparam logic [LEN_BITS-1:0] IDX_LAST = {LEN_BITS{1'b1}};

    dense_state_t        state_r;
    dense_state_t        state_nxt_s;
    logic [LEN_BITS-1:0] idx_r;
    logic                mac_clr_s;
    logic                mac_en_s;
    logic signed [31:0]  acc_s;
    logic signed [31:0]  bias_ext_s;
    logic signed [15:0]  logit_r;
    logic [15:0]         prob_r;
    logic                ready_r;
    logic [LEN_BITS-1:0] sel_s;

    fxp_mac #(
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr_s),
        .en    (mac_en_s),
        .a     (bus.h_data),
        .b     (bus.w_data),
        .acc   (acc_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and MAC control; start is only looked at in IDLE, so it never queues.
    always_comb begin
        state_nxt_s = state_r;
        mac_clr_s   = 1'b0;
        mac_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = MAC;
                    mac_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = BIAS;
                end else begin
                    state_nxt_s = MAC;
                end
            end
            BIAS: begin
                state_nxt_s = ACT;
            end
            ACT: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Element index: cleared on accept, stepped once per MAC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= IDX_ZERO;
        end else if (mac_clr_s) begin
            idx_r <= IDX_ZERO;
        end else if (mac_en_s) begin
            idx_r <= idx_r + IDX_ONE;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign bias_ext_s = {{16{bus.bias[15]}}, bus.bias};

    // Result registers: logit in BIAS, prob and the ready pulse in ACT; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logit_r <= 16'sd0;
            prob_r  <= 16'd0;
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                BIAS: begin
                    logit_r <= sat16(acc_s + bias_ext_s);
                end
                ACT: begin
                    prob_r  <= hard_sigmoid(logit_r, FRAC_BITS);
                    ready_r <= 1'b1;
                end
                default: begin
                    logit_r <= logit_r;
                    prob_r  <= prob_r;
                end
            endcase
        end
    end

    // The tensors are only addressed during MAC; sel parks at 0 elsewhere.
    always_comb begin
        sel_s = IDX_ZERO;
        if (state_r == MAC) begin
            sel_s = idx_r;
        end else begin
            sel_s = IDX_ZERO;
        end
    end

    assign bus.sel   = sel_s;
    assign bus.busy  = (state_r != IDLE);
    assign bus.ready = ready_r;
    assign bus.logit = logit_r;
    assign bus.prob  = prob_r;
endmodule

// File: tb/tb_dense_head.sv
// Self-checking bench for dense_head (N=16, FRAC_BITS=8). Expected logit/prob
// come from a whole-vector arithmetic model of the fixed-point dot product.
module tb_dense_head;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic signed [15:0] h_mem [16];
    logic signed [15:0] w_mem [16];

    dense_head_if #(.LEN_BITS(4)) bus ();

    dense_head #(
        .LEN_BITS  (4),
        .FRAC_BITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.h_data = h_mem[bus.sel];
    assign bus.w_data = w_mem[bus.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Floor division for a positive divisor.
    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model(output int lg, output int pb);
        longint s;
        longint p;
        s = 0;
        for (int i = 0; i < 16; i++)
            s += fdiv(longint'(h_mem[i]) * longint'(w_mem[i]), 256);
        s += longint'(bus.bias);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        lg = int'(s);
        p = fdiv(s, 4) + 128;
        if (p < 0) p = 0;
        else if (p > 256) p = 256;
        pb = int'(p);
    endtask

    task automatic fill(input int h0, input int w0, input int hr, input int wr, input int b);
        for (int i = 0; i < 16; i++) begin
            h_mem[i] = (i == 0) ? 16'(h0) : 16'(hr);
            w_mem[i] = (i == 0) ? 16'(w0) : 16'(wr);
        end
        bus.bias = 16'(b);
    endtask

    // Drive start across one edge (E0); returns #1 after E0.
    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // n counts cycles with E0 as 1; stops at the cycle where ready is seen.
    task automatic wait_ready(output int n);
        n = 1;
        while (n < 40 && bus.ready !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_check(input string tag);
        int lg;
        int pb;
        int n;
        model(lg, pb);
        do_start();
        check({tag, ".busy_after_start"}, 32'(bus.busy), 1);
        wait_ready(n);
        check({tag, ".latency"}, n, 19);
        check({tag, ".logit"}, bus.logit, lg);
        check({tag, ".prob"}, bus.prob, pb);
        check({tag, ".busy_in_ready"}, 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        check({tag, ".ready_drop"}, 32'(bus.ready), 0);
        check({tag, ".logit_hold"}, bus.logit, lg);
    endtask

    initial begin
        int lg;
        int pb;
        int n;
        int rdy_cnt;
        int rdy_at;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        fill(0, 0, 0, 0, 0);

        // Reset state
        #3;
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.ready", 32'(bus.ready), 0);
        check("rst.sel", 32'(bus.sel), 0);
        check("rst.logit", bus.logit, 0);
        check("rst.prob", bus.prob, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios
        fill(256, 256, 0, 0, -256);
        run_check("s1");
        check("s1.logit_const", bus.logit, 0);
        check("s1.prob_const", bus.prob, 128);
        fill(256, 128, 256, 128, 0);
        run_check("s2");
        check("s2.prob_const", bus.prob, 256);
        fill(1, -1, 0, 0, 0);
        run_check("s3");
        check("s3.logit_const", bus.logit, -1);
        check("s3.prob_const", bus.prob, 127);
        fill(32767, -32768, 32767, -32768, 0);
        run_check("s4a");
        check("s4a.logit_const", bus.logit, -32768);
        check("s4a.prob_const", bus.prob, 0);
        fill(32767, 32767, 32767, 32767, 0);
        run_check("s4b");
        check("s4b.logit_const", bus.logit, 32767);
        check("s4b.prob_const", bus.prob, 256);

        // Randomized vectors
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                h_mem[i] = 16'($urandom());
                w_mem[i] = (r < 3) ? 16'($urandom_range(0, 1023)) - 16'sd512 : 16'($urandom());
            end
            bus.bias = 16'($urandom());
            run_check($sformatf("rand%0d", r));
        end

        // Start pulses during a run are ignored; sel walks 0..15 once
        fill(256, 128, 256, 128, 0);
        model(lg, pb);
        do_start();
        check("s5.sel0", 32'(bus.sel), 0);
        rdy_cnt = 0;
        rdy_at  = 0;
        for (int k = 1; k <= 30; k++) begin
            bus.start = (k == 3 || k == 10) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            if (k < 16) check($sformatf("s5.sel%0d", k), 32'(bus.sel), k);
            if (k == 16) check("s5.sel_park", 32'(bus.sel), 0);
            if (bus.ready === 1'b1) begin
                rdy_cnt++;
                rdy_at = k;
            end
        end
        bus.start = 1'b0;
        check("s5.ready_count", rdy_cnt, 1);
        check("s5.ready_at", rdy_at, 18);
        check("s5.logit", bus.logit, lg);

        // Start in the ready cycle is accepted; results hold until the new run ends
        do_start();
        wait_ready(n);
        check("s5b.first_latency", n, 19);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        fill(1, -1, 0, 0, 0);
        check("s5b.busy_accept", 32'(bus.busy), 1);
        check("s5b.ready_low", 32'(bus.ready), 0);
        check("s5b.logit_hold", bus.logit, 2048);
        check("s5b.prob_hold", bus.prob, 256);
        model(lg, pb);
        wait_ready(n);
        check("s5b.latency", n, 19);
        check("s5b.logit", bus.logit, lg);
        check("s5b.prob", bus.prob, pb);

        // Reset in the middle of a run
        fill(256, 128, 256, 128, 0);
        do_start();
        n = 0;
        while (n < 30 && bus.sel !== 4'd5) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s6.reached_sel5", 32'(bus.sel), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6.busy", 32'(bus.busy), 0);
        check("s6.ready", 32'(bus.ready), 0);
        check("s6.sel", 32'(bus.sel), 0);
        check("s6.logit", bus.logit, 0);
        check("s6.prob", bus.prob, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill(256, 256, 0, 0, -256);
        run_check("s6.rerun");
        check("s6.rerun_logit", bus.logit, 0);
        check("s6.rerun_prob", bus.prob, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
